// File: rtl/frame_replay_buffer.sv
// Full-frame store between conv and pooling: capture one NUM_CH-channel map,
// replay it in raster order under valid/ready, then optionally emit zero flush beats.

module frame_replay_lane #(
  parameter int DEPTH = 196,
  parameter int AW    = 8,
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DATAW-1:0] wr_data,
  input  logic             rd_load,
  input  logic             rd_clear,
  input  logic [AW-1:0]    rd_addr,
  output logic [DATAW-1:0] rd_data
);
  logic [DATAW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Clearing the read register is what makes flush beats exact zeros.
  always_ff @(posedge clk) begin
    if (rst || rd_clear) rd_data <= '0;
    else if (rd_load)    rd_data <= mem[rd_addr];
  end
endmodule

module frame_replay_buffer #(
  parameter int IMG_W      = 14,
  parameter int IMG_H      = 14,
  parameter int NUM_CH     = 12,
  parameter int DATAW      = 32,
  parameter int FLUSH_LEN  = 0,
  parameter int AUTO_START = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*DATAW-1:0] in_data,
  input  logic                    start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*DATAW-1:0] out_data,
  output logic                    out_flush,
  output logic                    frame_done,
  output logic                    overflow,
  output logic                    busy
);
  localparam int FRAME = IMG_W * IMG_H;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int AW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int FW    = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(FRAME - 1);
  localparam logic [FW-1:0] LAST_FL  = FW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

  typedef enum logic [2:0] {S_FILL, S_WAIT, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] wr_cnt, rd_cnt, rd_nxt;
  logic [FW-1:0] fl_cnt;
  logic          wr_en, accept, rd_last, wr_last, fl_last;
  logic          rd_load, rd_clear, valid_nxt, flush_nxt;
  logic [AW-1:0] rd_addr;
  logic [NUM_CH-1:0][DATAW-1:0] in_lanes, out_lanes;

  assign in_lanes   = in_data;
  assign out_data   = out_lanes;
  assign in_ready   = (state == S_FILL);
  assign frame_done = (state == S_DONE);
  assign busy       = !((state == S_FILL) && (wr_cnt == '0));
  assign wr_en      = in_valid && in_ready;
  assign accept     = out_valid && out_ready;
  assign rd_nxt     = rd_cnt + CW'(1);
  assign wr_last    = (wr_cnt == LAST_PIX);
  assign rd_last    = (rd_cnt == LAST_PIX);
  assign fl_last    = (fl_cnt == LAST_FL);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  // The output register is (re)loaded whenever it is empty or its beat is taken,
  // so a stall simply holds it and no pixel is skipped or repeated.
  always_comb begin
    state_nxt = state;
    rd_load   = 1'b0;
    rd_clear  = 1'b0;
    rd_addr   = rd_cnt[AW-1:0];
    valid_nxt = out_valid;
    flush_nxt = out_flush;
    case (state)
      S_FILL:  if (wr_en && wr_last) state_nxt = (AUTO_START != 0) ? S_DRAIN : S_WAIT;
      S_WAIT:  if (start) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!out_valid) begin
          rd_load   = 1'b1;
          valid_nxt = 1'b1;
        end else if (accept) begin
          if (rd_last) begin
            rd_clear = 1'b1;
            if (FLUSH_LEN > 0) begin
              state_nxt = S_FLUSH;
              flush_nxt = 1'b1;
            end else begin
              state_nxt = S_DONE;
              valid_nxt = 1'b0;
            end
          end else begin
            rd_load = 1'b1;
            rd_addr = rd_nxt[AW-1:0];
          end
        end
      end
      S_FLUSH: begin
        rd_clear = 1'b1;
        if (accept && fl_last) begin
          state_nxt = S_DONE;
          valid_nxt = 1'b0;
          flush_nxt = 1'b0;
        end
      end
      S_DONE: begin
        rd_clear  = 1'b1;
        valid_nxt = 1'b0;
        flush_nxt = 1'b0;
        state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flush <= 1'b0;
    end else begin
      out_valid <= valid_nxt;
      out_flush <= flush_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == S_DONE) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + CW'(1);
      if (state == S_DRAIN && accept && !rd_last) rd_cnt <= rd_nxt;
      if (state == S_FLUSH && accept) fl_cnt <= fl_cnt + FW'(1);
    end
  end

  // Sticky: any beat offered while not in FILL is dropped and remembered.
  always_ff @(posedge clk) begin
    if (rst)                        overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    frame_replay_lane #(.DEPTH(FRAME), .AW(AW), .DATAW(DATAW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en && !rst),
      .wr_addr  (wr_cnt[AW-1:0]),
      .wr_data  (in_lanes[k]),
      .rd_load  (rd_load),
      .rd_clear (rd_clear),
      .rd_addr  (rd_addr),
      .rd_data  (out_lanes[k])
    );
  end
endmodule

// File: tb/tb_frame_replay_buffer.sv
// Bench for frame_replay_buffer: four instances (4x4 plain, 4x4 with 3 flush beats,
// 4x4 with manual start, 1x1) driven from a vector table plus a reset sequence.

module tb_frame_replay_buffer;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] in_valid, start, out_ready;
  logic [3:0][63:0] in_data;
  logic [3:0] in_ready, out_valid, out_flush, frame_done, overflow, busy;
  logic [3:0][63:0] out_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    frame_replay_buffer #(
      .IMG_W(g == 3 ? 1 : 4), .IMG_H(g == 3 ? 1 : 4), .NUM_CH(2), .DATAW(32),
      .FLUSH_LEN(g == 1 ? 3 : 0), .AUTO_START(g == 2 ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .start(start[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .out_flush(out_flush[g]), .frame_done(frame_done[g]),
      .overflow(overflow[g]), .busy(busy[g])
    );
  end

  typedef struct { logic [63:0] data; logic flush; } exp_t;
  typedef struct { int d; int base; int rdy; bit hold; int n; int flush; bit ovf; } vec_t;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  int act, beats, done_cnt, t_first;
  bit first_seen, hold_pending;
  logic [63:0] hold_data;
  logic hold_flush;

  function automatic logic [63:0] pix(input int v);
    return {32'(100 + v), 32'(v)};
  endfunction

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (hold_pending) begin
        check("stall_valid", out_valid[act], 1);
        check("stall_data", out_data[act], hold_data);
        check("stall_flush", out_flush[act], hold_flush);
      end
      hold_pending = out_valid[act] && !out_ready[act];
      hold_data    = out_data[act];
      hold_flush   = out_flush[act];
      if (out_valid[act] && !first_seen) begin
        first_seen = 1;
        t_first    = cyc;
      end
      if (out_valid[act] && out_ready[act]) begin
        beats++;
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL extra_beat: got %0h expected no beat", out_data[act]);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data[act], e.data);
          check("out_flush", out_flush[act], e.flush);
        end
      end
      if (frame_done[act]) begin
        done_cnt++;
        check("done_after_last", sb.size(), 0);
      end
    end
  endtask

  task automatic new_frame(input int d);
    act = d; beats = 0; done_cnt = 0; first_seen = 0; t_first = 0; hold_pending = 0;
  endtask

  task automatic write_frame(input int d, input int base, input int n, input bit push,
                             output int t_last);
    t_last = cyc;
    for (int i = 0; i < n; i++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = pix(base + i);
      t_last      = cyc;
      if (push) sb.push_back('{pix(base + i), 1'b0});
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d, input int mode, input bit hold, input int budget);
    bit got;
    got = 0;
    if (hold) begin
      in_valid[d] = 1'b1;
      in_data[d]  = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    for (int k = 0; k < budget && !got; k++) begin
      out_ready[d] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      if (hold && k == 0) check("overflow_first", overflow[d], 1);
      if (done_cnt > 0) got = 1;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
    check("drain_done", got, 1);
    check("in_ready_after_done", in_ready[d], 1);
    check("busy_after_done", busy[d], 0);
    check("done_one_cycle", frame_done[d], 0);
  endtask

  vec_t tv[8];
  int t_w;

  initial begin
    tv[0] = '{d:0, base:0,  rdy:0, hold:0, n:16, flush:0, ovf:0};
    tv[1] = '{d:0, base:0,  rdy:1, hold:0, n:16, flush:0, ovf:0};
    tv[2] = '{d:1, base:0,  rdy:0, hold:0, n:16, flush:3, ovf:0};
    tv[3] = '{d:1, base:20, rdy:1, hold:0, n:16, flush:3, ovf:0};
    tv[4] = '{d:2, base:0,  rdy:0, hold:0, n:16, flush:0, ovf:0};
    tv[5] = '{d:0, base:40, rdy:0, hold:1, n:16, flush:0, ovf:1};
    tv[6] = '{d:0, base:60, rdy:1, hold:0, n:16, flush:0, ovf:1};
    tv[7] = '{d:3, base:7,  rdy:1, hold:0, n:1,  flush:0, ovf:0};

    rst = 1'b1; in_valid = '0; start = '0; out_ready = '0; in_data = '0;
    act = 0; hold_pending = 0; first_seen = 0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < 4; d++) begin
      check("rst_in_ready", in_ready[d], 1);
      check("rst_out_valid", out_valid[d], 0);
      check("rst_out_data", out_data[d], 0);
      check("rst_out_flush", out_flush[d], 0);
      check("rst_frame_done", frame_done[d], 0);
      check("rst_overflow", overflow[d], 0);
      check("rst_busy", busy[d], 0);
    end

    for (int v = 0; v < 8; v++) begin
      new_frame(tv[v].d);
      write_frame(tv[v].d, tv[v].base, tv[v].n, 1, t_w);
      for (int f = 0; f < tv[v].flush; f++) sb.push_back('{64'h0, 1'b1});
      check("in_ready_drop", in_ready[tv[v].d], 0);
      if (tv[v].d == 2) begin
        for (int i = 0; i < 10; i++) begin
          check("wait_no_valid", out_valid[2], 0);
          @(posedge clk); #1;
        end
        check("wait_busy", busy[2], 1);
        start[2] = 1'b1;
        t_w = cyc;
        @(posedge clk); #1;
        start[2] = 1'b0;
      end
      drain(tv[v].d, tv[v].rdy, tv[v].hold, 400);
      check("latency", t_first - t_w, 2);
      check("beat_count", beats, tv[v].n + tv[v].flush);
      check("sb_empty", sb.size(), 0);
      check("overflow", overflow[tv[v].d], tv[v].ovf);
      repeat (3) @(posedge clk);
      #1 check("done_pulses", done_cnt, 1);
    end

    // Reset after a partial frame, with a write offered in the reset cycle itself.
    new_frame(0);
    write_frame(0, 200, 7, 0, t_w);
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = pix(999);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid[0] = 1'b0;
    check("rst_mid_overflow", overflow[0], 0);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_in_ready", in_ready[0], 1);
    check("rst_mid_out_valid", out_valid[0], 0);
    write_frame(0, 80, 16, 1, t_w);
    drain(0, 0, 0, 400);
    check("rst_latency", t_first - t_w, 2);
    check("rst_beat_count", beats, 16);
    check("rst_sb_empty", sb.size(), 0);
    check("rst_overflow_after", overflow[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/frame_replay_buffer.md
Name: frame_replay_buffer

Overview:
- Parametrised multi-channel full-frame store between a conv stage and a pooling stage.
- Captures one complete IMG_W x IMG_H feature map of NUM_CH channels, arriving one pixel per valid beat.
- Replays the map in raster order to the downstream stage under a valid/ready handshake.
- Then emits FLUSH_LEN zero-valued valid beats to drain the downstream window pipeline, and reports frame completion plus sticky error status.

Parameters:
- IMG_W, 14, feature-map width in pixels.
- IMG_H, 14, feature-map height in pixels.
- NUM_CH, 12, channels per pixel.
- DATAW, 32, bits per channel sample.
- FLUSH_LEN, 0, zero beats emitted after the last real pixel (0 = none).
- AUTO_START, 1, 1: drain starts the cycle after the frame fills; 0: drain waits for start.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input pixel beat valid.
- in_ready  out  1  buffer accepts input; high only in FILL.
- in_data  in  NUM_CH*DATAW  packed pixel; channel k at bits [k*DATAW +: DATAW].
- start  in  1  drain trigger, used only when AUTO_START=0.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  NUM_CH*DATAW  packed output pixel, same packing as in_data.
- out_flush  out  1  marks a zero flush beat (high together with out_valid).
- frame_done  out  1  one-cycle pulse after the final beat, real or flush, is accepted.
- overflow  out  1  sticky flag: an in_valid beat arrived while in_ready was low.
- busy  out  1  high in every state except FILL with wr_cnt==0.

Behaviour:
- Storage: FRAME = IMG_W*IMG_H entries, each NUM_CH*DATAW wide.
- Pointer widths: wr_cnt and rd_cnt are $clog2(FRAME+1) bits; fl_cnt is $clog2(FLUSH_LEN+1) bits, minimum 1.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_flush=0, frame_done=0, overflow=0, busy=0; all counters 0; state=FILL. Memory contents are not reset.
- FILL state:
  - in_valid && in_ready writes mem[wr_cnt] and increments wr_cnt.
  - On the write with wr_cnt==FRAME-1: in_ready drops next cycle. Go to DRAIN if AUTO_START=1, otherwise WAIT.
- WAIT state: in_ready=0. start=1 moves to DRAIN next cycle. start is ignored in every other state.
- DRAIN state:
  - out_data is a registered read of mem[rd_cnt].
  - out_valid rises 1 cycle after DRAIN entry, so fill-to-first-output latency is 2 cycles with AUTO_START=1.
  - A beat is accepted when out_valid && out_ready; rd_cnt then increments and the next pixel appears the following cycle. Throughput is 1 beat/cycle while out_ready stays high.
  - While out_ready=0, out_valid and out_data hold stable with no change and no skip.
  - When the beat with rd_cnt==FRAME-1 is accepted: go to FLUSH if FLUSH_LEN>0, otherwise DONE.
- FLUSH state:
  - out_valid=1, out_data=0, out_flush=1.
  - Each accepted beat increments fl_cnt; the FLUSH_LEN-th accepted beat moves to DONE.
- DONE state (1 cycle):
  - frame_done=1, out_valid=0, out_flush=0.
  - Counters clear; return to FILL with in_ready=1 the next cycle.
- No beat is ever lost or duplicated across a stall.
- overflow:
  - Set on any cycle with in_valid=1 && in_ready=0; that beat is dropped and never written.
  - Cleared only by rst.
  - Input arriving during DRAIN, FLUSH, WAIT or DONE is therefore dropped and flagged.
- FRAME=1: FILL goes straight to DRAIN after one write. Must work.
- rst mid-operation: wins over every other event in the same cycle. The state machine returns to FILL immediately, any partial frame is discarded, and the next frame starts at wr_cnt=0.
- No arithmetic on data: it passes bit-exact, and flush beats are exact zeros in every channel.

Test Plan:
- IMG_W=IMG_H=4, NUM_CH=2, FLUSH_LEN=0, AUTO_START=1. Write pixels 0..15 with ch0=i, ch1=100+i, out_ready=1 -> first out_valid 2 cycles after the 16th write; 16 consecutive beats in order; frame_done pulses once; in_ready high again the next cycle.
- Same frame, out_ready toggled pseudo-randomly during DRAIN -> output sequence identical to the previous test; out_data stable during every stall; no gaps in the index order.
- FLUSH_LEN=3 -> 16 data beats with out_flush=0, then exactly 3 beats with out_data=0 and out_flush=1; frame_done only after the 3rd flush beat is accepted.
- AUTO_START=0, frame full, start held low for 10 cycles -> out_valid stays 0 and busy=1; pulsing start gives first out_valid 2 cycles later.
- in_valid held high throughout DRAIN -> overflow=1 from the first rejected beat and stays 1 across the next frame; data of the next frame unaffected.
- rst asserted after 7 writes, then a fresh 16-pixel frame written -> output is exactly the fresh frame; overflow=0, no stale pixels.
